// File: rtl/mult_unit.sv
// Iterative radix-2^RADIX_BITS multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Multiplies operand magnitudes over N cycles, then applies the sign and selects a half.
module mult_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_a,
  input  logic             signed_b,
  input  logic             half,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned N    = WIDTH / RADIX_BITS;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e                  state_q;
  logic [WIDTH-1:0]        mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic [2*WIDTH-1:0]      acc_q;
  logic [CntW-1:0]         cnt_q;
  logic                    neg_q;
  logic                    half_q;

  logic [WIDTH-1:0]            a_mag;
  logic [WIDTH-1:0]            b_mag;
  logic                        neg_in;
  logic [WIDTH+RADIX_BITS-1:0] partial;
  logic [2*WIDTH-1:0]          addend;
  logic [2*WIDTH-1:0]          product;

  always_comb begin
    // |0x80000000| negates to itself, which is the correct unsigned magnitude.
    a_mag   = (signed_a && a[WIDTH-1]) ? -a : a;
    b_mag   = (signed_b && b[WIDTH-1]) ? -b : b;
    neg_in  = (signed_a & a[WIDTH-1]) ^ (signed_b & b[WIDTH-1]);
    partial = {{RADIX_BITS{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q[RADIX_BITS-1:0]};
    addend  = {{(WIDTH-RADIX_BITS){1'b0}}, partial} << (cnt_q * RADIX_BITS);
    product = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      half_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Squash without touching result; flush also beats a same-cycle start.
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              mcand_q  <= a_mag;
              mplier_q <= b_mag;
              neg_q    <= neg_in;
              half_q   <= half;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state_q  <= StCalc;
            end
          end
          StCalc: begin
            acc_q    <= acc_q + addend;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
              state_q <= StSign;
            end
          end
          StSign: begin
            result  <= half_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed RV32M cases, pipeline-control scenarios and a
// random sweep against a 64-bit arithmetic reference.
module tb_mult_unit;

  localparam int unsigned W = 32;
  localparam int unsigned R = 2;
  localparam int unsigned N = W / R;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         signed_a;
  logic         signed_b;
  logic         half;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_unit #(
    .WIDTH      (W),
    .RADIX_BITS (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .signed_a (signed_a),
    .signed_b (signed_b),
    .half     (half),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sx, input logic sy, input logic h);
    logic [63:0] ex, ey, p;
    ex = sx ? {{32{x[31]}}, x} : {32'b0, x};
    ey = sy ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ex * ey;
    return h ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle and returns in its done cycle (lat = -1 on timeout).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sx,
                        input logic sy, input logic h, output logic [31:0] res,
                        output int lat, output int nbusy);
    a = x; b = y; signed_a = sx; signed_b = sy; half = h; start = 1'b1;
    lat   = -1;
    nbusy = 0;
    for (int c = 1; c <= 4 * N; c++) begin
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy === 1'b1) nbusy++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    a = '0; b = '0; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (result !== 32'h0) begin
      failures++; $display("FAIL reset_result got=%h want=00000000", result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] xa [6] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h0};
    logic [31:0] xb [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h8000_0000};
    logic        xsa [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        xsb [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        xh  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] xr  [6] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'h0000_0001, 32'h0};
    logic [31:0] res;
    int lat, nb;
    for (int i = 0; i < 6; i++) begin
      run_op(xa[i], xb[i], xsa[i], xsb[i], xh[i], res, lat, nb);
      checks++;
      if (res !== xr[i]) begin
        failures++; $display("FAIL directed%0d_result got=%h want=%h", i, res, xr[i]);
      end
      checks++;
      if (lat != LAT) begin
        failures++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, LAT);
      end
      checks++;
      if (nb != N + 1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_busy cycles=%0d want=%0d busy_at_done=%b want=0",
                 i, nb, N + 1, busy);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, r1, r2;
    int l1, l2, nb;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    run_op(x1, y1, 1'b1, 1'b0, 1'b1, r1, l1, nb);
    // Second start issued in the first op's done cycle.
    run_op(x2, y2, 1'b0, 1'b1, 1'b0, r2, l2, nb);
    checks++;
    if (r1 !== ref_mul(x1, y1, 1'b1, 1'b0, 1'b1) || l1 != LAT) begin
      failures++;
      $display("FAIL b2b_first got=%h lat=%0d want=%h lat=%0d", r1, l1,
               ref_mul(x1, y1, 1'b1, 1'b0, 1'b1), LAT);
    end
    checks++;
    if (r2 !== ref_mul(x2, y2, 1'b0, 1'b1, 1'b0) || l2 != LAT) begin
      failures++;
      $display("FAIL b2b_second got=%h gap=%0d want=%h gap=%0d", r2, l2,
               ref_mul(x2, y2, 1'b0, 1'b1, 1'b0), LAT);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b want=0", done); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] x, y, res, exp;
    int ndone, dc;
    x = pick_operand(); y = pick_operand();
    exp = ref_mul(x, y, 1'b1, 1'b1, 1'b0);
    a = x; b = y; signed_a = 1'b1; signed_b = 1'b1; half = 1'b0; start = 1'b1;
    ndone = 0; dc = -1; res = '0;
    for (int c = 1; c <= 3 * N; c++) begin
      tick();
      start = (c == 5);
      if (c == 5) begin
        a = $urandom; b = $urandom; half = 1'b1; signed_a = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++; dc = c; res = result;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || dc != LAT) begin
      failures++;
      $display("FAIL busy_start_ignored dones=%0d at=%0d want dones=1 at=%0d", ndone, dc, LAT);
    end
    checks++;
    if (res !== exp) begin
      failures++; $display("FAIL busy_start_operands got=%h want=%h", res, exp);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat, nb, ndone;
    run_op(32'h1234_5678, 32'h9, 1'b0, 1'b0, 1'b0, prev, lat, nb);
    tick();
    a = $urandom; b = $urandom; signed_a = 1'b1; signed_b = 1'b1; half = 1'b1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL flush_calc busy=%b done=%b want busy=0 done=0", busy, done);
    end
    ndone = 0;
    for (int c = 0; c < 2 * N; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    res = result;
    checks++;
    if (ndone != 0 || res !== 32'hA3D7_0A38) begin
      failures++;
      $display("FAIL flush_no_done dones=%0d result=%h want dones=0 result=a3d70a38",
               ndone, res);
    end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b want=0", busy); end
    ndone = 0;
    for (int c = 0; c < N + 4; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++; $display("FAIL flush_start_activity cycles=%0d want=0", ndone);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] res;
    int lat, nb;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, res, lat, nb);
    tick();
    a = 32'h55; b = 32'h77; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, exp;
    logic sx, sy, h;
    int lat, nb;
    for (int i = 0; i < 2000; i++) begin
      x = pick_operand(); y = pick_operand();
      sx = 1'($urandom); sy = 1'($urandom); h = 1'($urandom);
      exp = ref_mul(x, y, sx, sy, h);
      run_op(x, y, sx, sy, h, res, lat, nb);
      checks++;
      if (res !== exp || lat != LAT) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h sa=%b sb=%b h=%b got=%h lat=%0d want=%h lat=%0d",
                 i, x, y, sx, sy, h, res, lat, exp, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_flush();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
